data_confreg_bridge: RTL and testbench
======================================

// Module: data_confreg_bridge
// PURPOSE
//  Downstream of the single-cycle core's data port: decodes each data access to data RAM
//  or an MMIO config-register window. Window holds LED, switch, free-running timer and a
//  FIFO-buffered 8N1 UART transmitter. Reads are combinational (core consumes rdata same cycle).
// PARAMETERS
//  CONF_BASE    32'hBFAF_0000  MMIO window base; hit when cpu_addr[31:16]==CONF_BASE[31:16]
//  CLK_PER_BIT  16             clk cycles per UART bit (>=2)
//  FIFO_DEPTH   4              UART TX FIFO entries (power of 2)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  cpu_we       in   1   core data write enable
//  cpu_addr     in   32  core data address
//  cpu_wdata    in   32  core write data
//  cpu_rdata    out  32  read data to core (combinational)
//  ram_we       out  1   data RAM write enable (cpu_we & ~hit)
//  ram_addr     out  32  = cpu_addr
//  ram_wdata    out  32  = cpu_wdata
//  ram_rdata    in   32  data RAM read data
//  led          out  16  LED register
//  sw           in   8   async switches
//  uart_txd     out  1   serial out, idle high
// BEHAVIOUR
//  - Interface fixed: clock clk; reset reset, synchronous, active-high.
//  - hit = cpu_addr[31:16]==CONF_BASE[31:16]; cpu_rdata = hit ? conf_rd : ram_rdata.
//  - Offsets (cpu_addr[15:0]): 0x000 LED RW[15:0]; 0x004 SW RO (synced, zero-ext);
//    0x008 TIMER RW; 0x00C UART_DATA WO (push wdata[7:0], reads 0);
//    0x010 UART_STAT RO {28'b0,ovf,busy,empty,full}; other offsets read 0, writes dropped.
//  - Writes take effect at the clock edge of the access cycle; a read the next cycle sees them.
//  - Reset values: led=0, timer=0, uart_txd=1, FIFO empty, ovf=0, sw sync flops=0.
//  - SW: 2-flop synchroniser; SW reads value 2 edges after pin change.
//  - TIMER: +1 every cycle, wraps 0xFFFF_FFFF->0; write loads cpu_wdata (write wins over +1).
//  - FIFO: push accepted only if count<FIFO_DEPTH before the edge; push when full is dropped,
//    sets sticky ovf. Any write to UART_STAT clears ovf. Push and pop same cycle both occur.
//  - UART FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//    IDLE: if FIFO non-empty, pop head, go START. Each of START/DATA bit/STOP held
//    CLK_PER_BIT cycles; txd=0 in START, data bit in DATA, 1 in STOP/IDLE.
//    Frame = 10*CLK_PER_BIT cycles; back-to-back frames with no idle gap.
//    busy = state!=IDLE; empty/full from FIFO count.
//  - Reset mid-frame aborts: txd=1 next cycle, FIFO flushed, in-flight byte lost.
// CONFIGURATION
//  - CONFREG_UART_EN defined: UART FIFO/FSM built as above.
//  - Not defined: no FIFO/FSM; uart_txd tied 1; UART_DATA writes ignored; UART_STAT reads
//    {28'b0,0,0,1,0} (empty, never busy); no UART flops instantiated.
// TESTING
//  1 RAM pass: st to 0x0000_0100, then ld -> ram_we=1 for the store, cpu_rdata=ram_rdata; ram_we=0 on MMIO stores.
//  2 LED: write 0xBFAF_0000 <- 0x1234_ABCD -> led=0xABCD next cycle; read returns 0x0000_ABCD.
//  3 Timer: after reset read N cycles later = N; write 0xFFFF_FFFE, reads next 2 cycles
//    0xFFFF_FFFE then 0xFFFF_FFFF, then 0x0 (wrap).
//  4 UART (EN): push 0xA5, CLK_PER_BIT=16 -> txd low 16 cycles, then bits 1,0,1,0,0,1,0,1,
//    then high; STAT busy=1 during frame, 0 after 160 cycles.
//  5 FIFO: 6 pushes in consecutive cycles while idle -> 1 popped immediately, 4 queued,
//    6th dropped; ovf=1; write STAT -> ovf=0; 5 frames sent back-to-back.
//  6 SW/reset: sw=0x5A -> SW reads 0x5A after 2 edges; assert reset mid-frame -> txd=1,
//    STAT=0x2 next cycle, led=0, timer=0.

Source files
------------

// File: rtl/data_confreg_bridge.sv
// Data-port address decoder: data RAM or an MMIO window with LED, switches, timer and UART TX.
// Optional UART FIFO/transmitter is built only when CONFREG_UART_EN is defined.
module data_confreg_bridge #(
    parameter logic [31:0] CONF_BASE   = 32'hBFAF_0000,
    parameter int          CLK_PER_BIT = 16,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  sw,
    output logic        uart_txd
);
    localparam logic [15:0] OFF_LED   = 16'h0000;
    localparam logic [15:0] OFF_SW    = 16'h0004;
    localparam logic [15:0] OFF_TIMER = 16'h0008;
    localparam logic [15:0] OFF_UDATA = 16'h000C;
    localparam logic [15:0] OFF_USTAT = 16'h0010;

    logic        w_hit;
    logic [15:0] w_off;
    logic        w_conf_we;
    logic [31:0] w_conf_rd;
    logic [31:0] w_stat;

    logic [15:0] r_led;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [31:0] r_timer;

    assign w_hit     = (cpu_addr[31:16] == CONF_BASE[31:16]);
    assign w_off     = cpu_addr[15:0];
    assign w_conf_we = cpu_we & w_hit;

    assign ram_we    = cpu_we & ~w_hit;
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign led       = r_led;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_timer   <= '0;
        end else begin
            if (w_conf_we && w_off == OFF_LED)
                r_led <= cpu_wdata[15:0];
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            // A software load replaces this cycle's increment.
            if (w_conf_we && w_off == OFF_TIMER)
                r_timer <= cpu_wdata;
            else
                r_timer <= r_timer + 32'd1;
        end
    end

`ifdef CONFREG_UART_EN
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_CNT_W = $clog2(CLK_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [7:0]           r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf;
    uart_state_t          r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_txd;

    uart_state_t          w_state_next;
    logic [BIT_CNT_W-1:0] w_bit_cnt_next;
    logic [2:0]           w_bit_idx_next;
    logic [7:0]           w_shift_next;
    logic                 w_txd_next;
    logic                 w_pop;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_bit_last;
    logic [7:0]           w_fifo_head;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push_req   = w_conf_we && (w_off == OFF_UDATA);
    assign w_push       = w_push_req && !w_fifo_full;
    assign w_fifo_head  = r_fifo[r_rd_ptr];
    assign w_bit_last   = (r_bit_cnt == BIT_CNT_W'(CLK_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= cpu_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_conf_we && w_off == OFF_USTAT)
                r_ovf <= 1'b0;
            else if (w_push_req && !w_push)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_fifo_head;
                    w_bit_cnt_next = '0;
                    w_state_next   = S_START;
                end
            end
            S_START: begin
                if (w_bit_last) begin
                    w_bit_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = S_DATA;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_last) begin
                    w_bit_cnt_next = '0;
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7)
                        w_state_next = S_STOP;
                    else
                        w_bit_idx_next = r_bit_idx + 3'd1;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit so queued frames have no idle gap.
                if (w_bit_last) begin
                    w_bit_cnt_next = '0;
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_head;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        case (w_state_next)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = w_shift_next[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    assign w_stat   = {28'b0, r_ovf, (r_state != S_IDLE), w_fifo_empty, w_fifo_full};
    assign uart_txd = r_txd;
`else
    assign w_stat   = 32'h0000_0002;
    assign uart_txd = 1'b1;
`endif

    always_comb begin
        w_conf_rd = '0;
        case (w_off)
            OFF_LED:   w_conf_rd = {16'b0, r_led};
            OFF_SW:    w_conf_rd = {24'b0, r_sw_sync};
            OFF_TIMER: w_conf_rd = r_timer;
            OFF_USTAT: w_conf_rd = w_stat;
            default:   w_conf_rd = '0;
        endcase
    end

    assign cpu_rdata = w_hit ? w_conf_rd : ram_rdata;

endmodule

// File: tb/tb_data_confreg_bridge.sv
// Bench for data_confreg_bridge: read scoreboard plus a UART frame monitor fed by an expected-byte queue.
module tb_data_confreg_bridge;
    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'hBFAF_0000;
`ifdef CONFREG_UART_EN
    localparam bit UEN = 1'b1;
`else
    localparam bit UEN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] led;
    logic [7:0]  sw;
    logic        uart_txd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int frames_done = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] uart_q[$];
    logic [31:0] bram [0:255];

    data_confreg_bridge #(
        .CONF_BASE  (BASE),
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .led      (led),
        .sw       (sw),
        .uart_txd (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (ram_we) bram[ram_addr[9:2]] <= ram_wdata;
    assign ram_rdata = bram[ram_addr[9:2]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, optionally queue the expected read, compare at negedge, advance one edge.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chk, input logic [31:0] exp, input string tag);
        rd_exp_t e;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (chk) begin
            e.tag = tag;
            e.exp = exp;
            rd_q.push_back(e);
        end
        @(negedge clk);
        check_eq("ram_we", {31'b0, ram_we}, {31'b0, we && (addr[31:16] != BASE[31:16])});
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check_eq(e.tag, cpu_rdata, e.exp);
        end
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART monitor: every start bit pops an expected byte and checks all 10*CPB samples.
    initial begin : uart_mon
        logic [9:0] frame;
        logic [9:0] rx;
        int  errs;
        bit  aborted;
        bit  b2b;
        int  last_start;
        b2b = 1'b0;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                b2b = 1'b0;
            end else if (uart_txd === 1'b0) begin
                if (b2b)
                    check_eq("uart_gap", cyc - last_start, 10 * CPB);
                last_start = cyc;
                check_eq("uart_expected", {31'b0, uart_q.size() != 0}, 32'd1);
                if (uart_q.size() != 0)
                    frame = {1'b1, uart_q.pop_front(), 1'b0};
                else
                    frame = 10'h200;
                errs = 0;
                aborted = 1'b0;
                rx = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                        end else begin
                            if (uart_txd !== frame[b]) errs++;
                            if (c == CPB / 2) rx[b] = uart_txd;
                        end
                    end
                end
                if (!aborted) begin
                    check_eq("uart_byte", {24'b0, rx[8:1]}, {24'b0, frame[8:1]});
                    check_eq("uart_shape", errs, 0);
                    frames_done++;
                    b2b = (uart_q.size() > 0);
                end else begin
                    b2b = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fr0;
        int fr1;
        for (int i = 0; i < 256; i++) bram[i] = '0;
        reset = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        sw = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and free-running timer.
        check_eq("led_rst", {16'b0, led}, 32'h0);
        check_eq("txd_rst", {31'b0, uart_txd}, 32'h1);
        idle(5);
        step(0, BASE + 32'h8, 0, 1, 32'd5, "timer_n");
        step(0, BASE + 32'h4, 0, 1, 32'h0, "sw_rst");
        step(0, BASE + 32'h10, 0, 1, 32'h2, "stat_rst");

        // RAM pass-through and decode boundary.
        step(1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, "");
        step(0, 32'h0000_0100, 0, 1, 32'hDEAD_BEEF, "ram_ld");
        step(0, 32'hBFAE_0100, 0, 1, 32'hDEAD_BEEF, "near_miss");

        // LED register, unmapped offsets.
        step(1, BASE, 32'h1234_ABCD, 0, 0, "");
        check_eq("led_wr", {16'b0, led}, 32'h0000_ABCD);
        step(0, BASE, 0, 1, 32'h0000_ABCD, "led_rd");
        step(0, 32'h0000_0000, 0, 1, 32'h0, "ram_untouched");
        step(1, BASE + 32'h20, 32'hFFFF_FFFF, 0, 0, "");
        step(0, BASE + 32'h20, 0, 1, 32'h0, "unmapped_rd");
        step(0, BASE + 32'hC, 0, 1, 32'h0, "udata_rd");
        step(0, BASE, 0, 1, 32'h0000_ABCD, "led_keep");

        // Timer load and wrap.
        step(1, BASE + 32'h8, 32'hFFFF_FFFE, 0, 0, "");
        step(0, BASE + 32'h8, 0, 1, 32'hFFFF_FFFE, "timer_ld");
        step(0, BASE + 32'h8, 0, 1, 32'hFFFF_FFFF, "timer_max");
        step(0, BASE + 32'h8, 0, 1, 32'h0, "timer_wrap");

        // Switch synchroniser latency.
        sw = 8'h5A;
        step(0, BASE + 32'h4, 0, 1, 32'h0, "sw_e0");
        step(0, BASE + 32'h4, 0, 1, 32'h0, "sw_e1");
        step(0, BASE + 32'h4, 0, 1, 32'h5A, "sw_e2");

        // Single frame: status across the whole frame.
        if (UEN) uart_q.push_back(8'hA5);
        step(1, BASE + 32'hC, 32'h0000_00A5, 0, 0, "");
        for (int k = 1; k <= 162; k++) begin
            logic [31:0] e;
            if (!UEN)        e = 32'h2;
            else if (k == 1) e = 32'h0;
            else if (k <= 161) e = 32'h6;
            else             e = 32'h2;
            step(0, BASE + 32'h10, 0, (k == 1 || k == 2 || k == 161 || k == 162), e, "stat_frame");
        end

        // FIFO overflow, sticky ovf, back-to-back drain.
        fr0 = frames_done;
        for (int i = 0; i < 6; i++) begin
            if (UEN && i < 5) uart_q.push_back(8'h30 + 8'(i));
            step(1, BASE + 32'hC, 32'h30 + i, 0, 0, "");
        end
        step(0, BASE + 32'h10, 0, 1, UEN ? 32'hD : 32'h2, "stat_ovf");
        step(1, BASE + 32'h10, 32'h0, 0, 0, "");
        step(0, BASE + 32'h10, 0, 1, UEN ? 32'h5 : 32'h2, "stat_ovf_clr");
        for (int i = 0; i < 2000 && frames_done < fr0 + (UEN ? 5 : 0); i++) idle(1);
        check_eq("frames_sent", frames_done - fr0, UEN ? 32'd5 : 32'd0);
        check_eq("uart_q_drained", uart_q.size(), 32'd0);
        idle(2);
        step(0, BASE + 32'h10, 0, 1, 32'h2, "stat_idle");

        // Reset mid-frame aborts the frame and flushes the FIFO.
        for (int i = 0; i < 3; i++) begin
            if (UEN) uart_q.push_back(8'h61 + 8'(i));
            step(1, BASE + 32'hC, 32'h61 + i, 0, 0, "");
        end
        idle(40);
        fr1 = frames_done;
        reset = 1'b1;
        uart_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("txd_after_rst", {31'b0, uart_txd}, 32'h1);
        check_eq("led_after_rst", {16'b0, led}, 32'h0);
        step(0, BASE + 32'h8, 0, 1, 32'h0, "timer_after_rst");
        step(0, BASE + 32'h10, 0, 1, 32'h2, "stat_after_rst");
        idle(400);
        check_eq("frames_after_rst", frames_done - fr1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
